// File: rtl/axi_mem_sink_ram.sv
// ---------------------------------------------------------------------------
// axi_mem_sink_ram
//
// AXI-MM responder that terminates a host-memory style initiator into a small
// on-chip line RAM (one 64-byte line per beat). Write and read channels run
// independently, each with one outstanding INCR burst. Beats whose line index
// falls outside the RAM are dropped (writes) or return zero data (reads) and
// the transaction is answered with SLVERR.
//
// Ports
//   clk_i, reset_i                     clock, asynchronous active-high reset
//   awvalid_i/awready_o, aw_*_i        write address channel
//   wvalid_i/wready_o, w_*_i           write data channel
//   bvalid_o/bready_i, b_*_o           write response channel
//   arvalid_i/arready_o, ar_*_i        read address channel
//   rvalid_o/rready_i, r_*_o           read data channel
// ---------------------------------------------------------------------------
module axi_mem_sink_ram #(
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 512,
    parameter int ID_WIDTH    = 8,
    parameter int USER_WIDTH  = 8,
    parameter int DEPTH_LINES = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    // write address
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic [7:0]              aw_len_i,
    input  logic [ID_WIDTH-1:0]     aw_id_i,
    input  logic [USER_WIDTH-1:0]   aw_user_i,
    // write data
    input  logic                    wvalid_i,
    output logic                    wready_o,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                    w_last_i,
    // write response
    output logic                    bvalid_o,
    input  logic                    bready_i,
    output logic [1:0]              b_resp_o,
    output logic [ID_WIDTH-1:0]     b_id_o,
    output logic [USER_WIDTH-1:0]   b_user_o,
    // read address
    input  logic                    arvalid_i,
    output logic                    arready_o,
    input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic [7:0]              ar_len_i,
    input  logic [ID_WIDTH-1:0]     ar_id_i,
    input  logic [USER_WIDTH-1:0]   ar_user_i,
    // read data
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_last_o,
    output logic [ID_WIDTH-1:0]     r_id_o,
    output logic [USER_WIDTH-1:0]   r_user_o
);

    // Line index carries one extra MSB so base+beat never wraps back into range.
    localparam int LW = ADDR_WIDTH - 6;
    localparam int IW = $clog2(DEPTH_LINES);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [LW:0] DEPTH_L = (LW + 1)'(DEPTH_LINES);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_LINES];

    // ---------------- write side ----------------
    w_state_e              w_state_q, w_state_d;
    logic [LW:0]           wr_base_q;
    logic [7:0]            wr_beat_q;
    logic [7:0]            wr_len_q;
    logic                  wr_err_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            b_resp_q;
    logic [ID_WIDTH-1:0]   b_id_q;
    logic [USER_WIDTH-1:0] b_user_q;

    logic                  aw_hs_s, w_hs_s, b_hs_s;
    logic [LW:0]           wr_line_s;
    logic                  wr_inrange_s, wr_is_last_s, wr_en_s, wr_err_next_s;

    // Write-channel handshakes and address of the current beat.
    always_comb begin
        aw_hs_s       = awvalid_i & awready_q;
        w_hs_s        = wvalid_i & wready_q;
        b_hs_s        = bvalid_q & bready_i;
        wr_line_s     = wr_base_q + {{(LW - 7){1'b0}}, wr_beat_q};
        wr_inrange_s  = (wr_line_s < DEPTH_L);
        wr_is_last_s  = (wr_beat_q == wr_len_q);
        wr_en_s       = w_hs_s & wr_inrange_s;
        // A mismatched w_last is a protocol error but never shortens the burst.
        wr_err_next_s = wr_err_q | ~wr_inrange_s | (w_last_i != wr_is_last_s);
    end

    // Write FSM next-state logic.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) w_state_d = W_DATA;
                else         w_state_d = W_IDLE;
            end
            W_DATA: begin
                if (w_hs_s && wr_is_last_s) w_state_d = W_RESP;
                else                        w_state_d = W_DATA;
            end
            W_RESP: begin
                if (b_hs_s) w_state_d = W_IDLE;
                else        w_state_d = W_RESP;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM state register with registered handshake outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE);
            wready_q  <= (w_state_d == W_DATA);
            bvalid_q  <= (w_state_d == W_RESP);
        end
    end

    // Write burst context: latched AW payload, beat counter, error flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_base_q <= '0;
            wr_beat_q <= 8'd0;
            wr_len_q  <= 8'd0;
            wr_err_q  <= 1'b0;
            b_resp_q  <= 2'b00;
            b_id_q    <= '0;
            b_user_q  <= '0;
        end else if (aw_hs_s) begin
            wr_base_q <= {1'b0, aw_addr_i[ADDR_WIDTH-1:6]};
            wr_beat_q <= 8'd0;
            wr_len_q  <= aw_len_i;
            wr_err_q  <= 1'b0;
            b_id_q    <= aw_id_i;
            b_user_q  <= aw_user_i;
        end else if (w_hs_s) begin
            wr_beat_q <= wr_beat_q + 8'd1;
            wr_err_q  <= wr_err_next_s;
            if (wr_is_last_s) b_resp_q <= wr_err_next_s ? 2'b10 : 2'b00;
        end
    end

    // Line RAM byte-strobed write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            for (int b = 0; b < NB; b++) begin
                if (w_strb_i[b]) mem_q[wr_line_s[IW-1:0]][b*8 +: 8] <= w_data_i[b*8 +: 8];
            end
        end
    end

    // ---------------- read side ----------------
    r_state_e              r_state_q, r_state_d;
    logic [LW:0]           rd_base_q;
    logic [7:0]            rd_beat_q;
    logic [7:0]            rd_len_q;
    logic                  arready_q, rvalid_q, r_last_q;
    logic [1:0]            r_resp_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [USER_WIDTH-1:0] r_user_q;

    logic                  ar_hs_s, r_hs_s, fetch_en_s, fetch_inrange_s;
    logic [7:0]            fetch_beat_s;
    logic [LW:0]           fetch_line_s;

    // Read fetch control: the first beat is fetched in R_FETCH; each accepted
    // non-final beat fetches its successor in the same cycle (no bubble).
    always_comb begin
        ar_hs_s    = arvalid_i & arready_q;
        r_hs_s     = rvalid_q & rready_i;
        fetch_en_s = (r_state_q == R_FETCH) | ((r_state_q == R_DATA) & r_hs_s & ~r_last_q);
        if (r_state_q == R_FETCH) fetch_beat_s = rd_beat_q;
        else                      fetch_beat_s = rd_beat_q + 8'd1;
        fetch_line_s    = rd_base_q + {{(LW - 7){1'b0}}, fetch_beat_s};
        fetch_inrange_s = (fetch_line_s < DEPTH_L);
    end

    // Read FSM next-state logic.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) r_state_d = R_FETCH;
                else         r_state_d = R_IDLE;
            end
            R_FETCH: r_state_d = R_DATA;
            R_DATA: begin
                if (r_hs_s && r_last_q) r_state_d = R_IDLE;
                else                    r_state_d = R_DATA;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM state register with registered handshake outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= (r_state_d == R_DATA);
        end
    end

    // Read burst context and registered R payload.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_base_q <= '0;
            rd_beat_q <= 8'd0;
            rd_len_q  <= 8'd0;
            r_id_q    <= '0;
            r_user_q  <= '0;
            r_data_q  <= '0;
            r_resp_q  <= 2'b00;
            r_last_q  <= 1'b0;
        end else if (ar_hs_s) begin
            rd_base_q <= {1'b0, ar_addr_i[ADDR_WIDTH-1:6]};
            rd_beat_q <= 8'd0;
            rd_len_q  <= ar_len_i;
            r_id_q    <= ar_id_i;
            r_user_q  <= ar_user_i;
        end else if (fetch_en_s) begin
            rd_beat_q <= fetch_beat_s;
            r_data_q  <= fetch_inrange_s ? mem_q[fetch_line_s[IW-1:0]] : '0;
            r_resp_q  <= fetch_inrange_s ? 2'b00 : 2'b10;
            r_last_q  <= (fetch_beat_s == rd_len_q);
        end else if (r_hs_s && r_last_q) begin
            r_last_q  <= 1'b0;
        end
    end

    // Byte-offset address bits carry no meaning for whole-line beats.
    logic unused_s;
    assign unused_s = ^{aw_addr_i[5:0], ar_addr_i[5:0]};

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign b_resp_o  = b_resp_q;
    assign b_id_o    = b_id_q;
    assign b_user_o  = b_user_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign r_data_o  = r_data_q;
    assign r_resp_o  = r_resp_q;
    assign r_last_o  = r_last_q;
    assign r_id_o    = r_id_q;
    assign r_user_o  = r_user_q;

endmodule

// File: tb/tb_axi_mem_sink_ram.sv
module tb_axi_mem_sink_ram;
    localparam int AW = 48;
    localparam int DW = 512;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i = 1'b1;
    logic          awvalid = 1'b0, awready;
    logic [AW-1:0] aw_addr = '0;
    logic [7:0]    aw_len = 8'd0, aw_id = 8'd0, aw_user = 8'd0;
    logic          wvalid = 1'b0, wready;
    logic [DW-1:0] w_data = '0;
    logic [63:0]   w_strb = '0;
    logic          w_last = 1'b0;
    logic          bvalid, bready = 1'b1;
    logic [1:0]    b_resp;
    logic [7:0]    b_id, b_user;
    logic          arvalid = 1'b0, arready;
    logic [AW-1:0] ar_addr = '0;
    logic [7:0]    ar_len = 8'd0, ar_id = 8'd0, ar_user = 8'd0;
    logic          rvalid, rready = 1'b1;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          r_last;
    logic [7:0]    r_id, r_user;

    axi_mem_sink_ram dut (
        .clk_i(clk), .reset_i(reset_i),
        .awvalid_i(awvalid), .awready_o(awready), .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .aw_id_i(aw_id), .aw_user_i(aw_user),
        .wvalid_i(wvalid), .wready_o(wready), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
        .bvalid_o(bvalid), .bready_i(bready), .b_resp_o(b_resp), .b_id_o(b_id), .b_user_o(b_user),
        .arvalid_i(arvalid), .arready_o(arready), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .ar_id_i(ar_id), .ar_user_i(ar_user),
        .rvalid_o(rvalid), .rready_i(rready), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
        .r_id_o(r_id), .r_user_o(r_user)
    );

    int total = 0;
    int bad = 0;
    int r_rx = 0;

    typedef struct { logic [1:0] resp; logic [7:0] id; logic [7:0] user; } b_exp_t;
    typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; logic [7:0] id; logic [7:0] user; } r_exp_t;
    b_exp_t b_q[$];
    r_exp_t r_q[$];

    // Reference memory: array of lines updated from the write rules directly.
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] wdat [256];
    logic [63:0]   wstb [256];
    bit rr_rand = 1'b0;
    bit br_rand = 1'b0;

    task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s timeout", nm);
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Ready drivers: random or always-ready, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bready = br_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every B/R handshake; checks R stability under stall.
    initial begin
        r_exp_t e;
        b_exp_t be;
        logic          stall = 1'b0;
        logic [DW-1:0] p_data;
        logic [1:0]    p_resp;
        logic          p_last;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                stall = 1'b0;
            end else begin
                if (bvalid && bready) begin
                    if (b_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b_unexpected got=%0h exp=none", b_id);
                    end else begin
                        be = b_q.pop_front();
                        check("b_resp", DW'(b_resp), DW'(be.resp));
                        check("b_id", DW'(b_id), DW'(be.id));
                        check("b_user", DW'(b_user), DW'(be.user));
                    end
                end
                if (stall) begin
                    check("r_hold_valid", DW'(rvalid), DW'(1'b1));
                    check("r_hold_data", r_data, p_data);
                    check("r_hold_resp_last", DW'({r_resp, r_last}), DW'({p_resp, p_last}));
                end
                if (rvalid && rready) begin
                    r_rx++;
                    if (r_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL r_unexpected got=%0h exp=none", r_id);
                    end else begin
                        e = r_q.pop_front();
                        check("r_data", r_data, e.data);
                        check("r_resp", DW'(r_resp), DW'(e.resp));
                        check("r_last", DW'(r_last), DW'(e.last));
                        check("r_id", DW'(r_id), DW'(e.id));
                        check("r_user", DW'(r_user), DW'(e.user));
                    end
                end
                stall  = rvalid && !rready;
                p_data = r_data;
                p_resp = r_resp;
                p_last = r_last;
            end
        end
    end

    // mode 0: random data, full strobes; 1: random data and strobes; 2: preset wdat/wstb.
    task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [7:0] id,
                            input logic [7:0] user, input int mode, input bit early_last, input bit chk);
        logic [AW-6:0] ln;
        logic          err;
        bit            lst;
        int            g;
        b_exp_t        e;
        err = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if (mode == 0) begin wdat[k] = rand_line(); wstb[k] = '1; end
            if (mode == 1) begin wdat[k] = rand_line(); wstb[k] = {$urandom, $urandom}; end
            ln  = {1'b0, addr[AW-1:6]} + (AW-5)'(k);
            lst = early_last ? (k == 0) : (k == len);
            if (ln >= (AW-5)'(DEPTH)) err = 1'b1;
            if (lst != (k == len)) err = 1'b1;
        end
        e.resp = err ? 2'b10 : 2'b00;
        e.id   = id;
        e.user = user;
        b_q.push_back(e);
        @(posedge clk); #1;
        aw_addr = addr; aw_len = 8'(len); aw_id = id; aw_user = user; awvalid = 1'b1;
        g = 0;
        do begin @(negedge clk); g++; end while (!awready && g < 100);
        if (!awready) timeout("aw_accept");
        @(posedge clk); #1;
        awvalid = 1'b0;
        if (chk) check("wready_after_aw", DW'(wready), DW'(1'b1));
        for (int k = 0; k <= len; k++) begin
            if (!chk) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            ln     = {1'b0, addr[AW-1:6]} + (AW-5)'(k);
            w_data = wdat[k];
            w_strb = wstb[k];
            w_last = early_last ? (k == 0) : (k == len);
            wvalid = 1'b1;
            g = 0;
            do begin @(negedge clk); g++; end while (!wready && g < 100);
            if (!wready) timeout("w_accept");
            if (ln < (AW-5)'(DEPTH)) begin
                for (int b = 0; b < 64; b++)
                    if (wstb[k][b]) mdl[int'(ln)][b*8 +: 8] = wdat[k][b*8 +: 8];
            end
            @(posedge clk); #1;
            wvalid = 1'b0;
            if (chk && k == len) check("bvalid_latency", DW'(bvalid), DW'(1'b1));
        end
        g = 0;
        while (b_q.size() != 0 && g < 2000) begin @(negedge clk); g++; end
        if (b_q.size() != 0) begin timeout("b_drain"); b_q.delete(); end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [7:0] id,
                           input logic [7:0] user, input bit chk, input bit nowait);
        logic [AW-6:0] ln;
        r_exp_t        e;
        int            g;
        for (int k = 0; k <= len; k++) begin
            ln     = {1'b0, addr[AW-1:6]} + (AW-5)'(k);
            e.data = (ln < (AW-5)'(DEPTH)) ? mdl[int'(ln[5:0])] : '0;
            e.resp = (ln < (AW-5)'(DEPTH)) ? 2'b00 : 2'b10;
            e.last = (k == len);
            e.id   = id;
            e.user = user;
            r_q.push_back(e);
        end
        @(posedge clk); #1;
        ar_addr = addr; ar_len = 8'(len); ar_id = id; ar_user = user; arvalid = 1'b1;
        g = 0;
        do begin @(negedge clk); g++; end while (!arready && g < 100);
        if (!arready) timeout("ar_accept");
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (chk) begin
            check("rvalid_fetch_cycle", DW'(rvalid), DW'(1'b0));
            @(posedge clk); #1;
            check("rvalid_latency", DW'(rvalid), DW'(1'b1));
        end
        if (!nowait) begin
            g = 0;
            while (r_q.size() != 0 && g < 3000) begin @(negedge clk); g++; end
            if (r_q.size() != 0) begin timeout("r_drain"); r_q.delete(); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] hello;
        int            g;
        int            tgt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", DW'(awready), DW'(1'b1));
        check("rst_arready", DW'(arready), DW'(1'b1));
        check("rst_wready", DW'(wready), DW'(1'b0));
        check("rst_bvalid", DW'(bvalid), DW'(1'b0));
        check("rst_rvalid", DW'(rvalid), DW'(1'b0));
        check("rst_rlast", DW'(r_last), DW'(1'b0));
        check("rst_bresp", DW'(b_resp), DW'(2'b00));
        check("rst_rresp", DW'(r_resp), DW'(2'b00));
        @(posedge clk); #1;
        reset_i = 1'b0;

        // Fill the whole RAM so every later read has defined contents.
        do_write(48'h0, 63, 8'h01, 8'h11, 0, 1'b0, 1'b0);

        // Single line write and read-back with latency checks.
        hello = '0;
        hello[95:0] = "Hello world!";
        wdat[0] = hello; wstb[0] = '1;
        do_write(48'h40, 0, 8'd5, 8'h33, 2, 1'b0, 1'b1);
        do_read(48'h40, 0, 8'd7, 8'h44, 1'b1, 1'b0);

        // Partial strobe over an all-ones line.
        wdat[0] = '1; wstb[0] = '1;
        do_write(48'hC0, 0, 8'd2, 8'h02, 2, 1'b0, 1'b0);
        wdat[0] = '0; wstb[0] = 64'h0F;
        do_write(48'hC0, 0, 8'd3, 8'h03, 2, 1'b0, 1'b0);
        do_read(48'hC0, 0, 8'd4, 8'h04, 1'b0, 1'b0);

        // Burst reaching the top of the RAM, then reading past the end.
        do_write(48'(60 * 64), 3, 8'h21, 8'h22, 0, 1'b0, 1'b0);
        do_read(48'(60 * 64), 7, 8'h23, 8'h24, 1'b0, 1'b0);

        // Early w_last: both beats still consumed and committed, SLVERR.
        do_write(48'(10 * 64), 1, 8'h31, 8'h32, 0, 1'b1, 1'b0);
        do_read(48'(10 * 64), 1, 8'h33, 8'h34, 1'b0, 1'b0);

        // Stalled long read concurrent with writes to disjoint lines.
        rr_rand = 1'b1; br_rand = 1'b1;
        fork
            do_read(48'(20 * 64), 15, 8'hA1, 8'h5C, 1'b0, 1'b0);
            for (int i = 0; i < 6; i++)
                do_write(48'((40 + 2 * i) * 64), $urandom_range(0, 1), 8'(8'h60 + i), 8'(8'h70 + i), 1, 1'b0, 1'b0);
        join

        // Randomized mix, including out-of-range lines.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(48'($urandom_range(0, 70) * 64 + $urandom_range(0, 63)), $urandom_range(0, 7),
                         8'($urandom), 8'($urandom), 1, 1'($urandom_range(0, 3) == 0), 1'b0);
            else
                do_read(48'($urandom_range(0, 70) * 64 + $urandom_range(0, 63)), $urandom_range(0, 7),
                        8'($urandom), 8'($urandom), 1'b0, 1'b0);
        end

        // Reset in the middle of an 8-beat read.
        rr_rand = 1'b0; br_rand = 1'b0;
        tgt = r_rx + 2;
        do_read(48'(8 * 64), 7, 8'h55, 8'h66, 1'b0, 1'b1);
        g = 0;
        while (r_rx < tgt && g < 200) begin @(negedge clk); g++; end
        if (r_rx < tgt) timeout("r_before_reset");
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(negedge clk);
        check("rst_mid_rvalid", DW'(rvalid), DW'(1'b0));
        check("rst_mid_arready", DW'(arready), DW'(1'b1));
        r_q.delete();
        @(posedge clk); #1;
        reset_i = 1'b0;
        do_read(48'(8 * 64), 3, 8'h57, 8'h68, 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
